pixel_frame_streamer: RTL
=========================

Name: pixel_frame_streamer

Overview:
Raster-scan source that reads a stored grayscale frame from a synchronous-read frame RAM and streams it one 8-bit pixel per cycle into the window/line-buffer stage (data + write-enable pair) that builds texture-feature windows. It is the producer end of that pixel stream. It adds a ready/valid backpressure path and frame/line markers so downstream stages can stall and resynchronise.

Parameters:
IMG_W, 64, pixels per line
IMG_H, 64, lines per frame
DATA_W, 8, bits per pixel
ADDR_W, $clog2(IMG_W*IMG_H), frame RAM address width

Ports:
i_clk  in  1  clock, rising-edge
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  start one frame; sampled only in IDLE
o_busy  out  1  high in RUN and DRAIN
o_done  out  1  one-cycle pulse after the last pixel transfers
o_mem_rden  out  1  frame RAM read strobe
o_mem_addr  out  ADDR_W  frame RAM read address, row-major (y*IMG_W+x)
i_mem_data  in  DATA_W  RAM read data, valid the cycle after the edge that sampled o_mem_rden
o_data  out  DATA_W  pixel to downstream
o_wren  out  1  pixel valid (downstream write enable)
i_ready  in  1  downstream accepts; transfer = o_wren & i_ready at a rising edge
o_sof  out  1  qualifies o_data as pixel (0,0)
o_eol  out  1  qualifies o_data as x = IMG_W-1
o_eof  out  1  qualifies o_data as last pixel of frame

Behaviour:
- Reset (i_rst high at an edge): state IDLE, read counter 0, skid buffer empty, in-flight flag 0; o_busy, o_done, o_mem_rden, o_wren, o_sof, o_eol, o_eof = 0; o_data, o_mem_addr = 0. Reset mid-frame abandons the frame: outstanding read data is discarded; no o_done.
- FSM: IDLE -> RUN on i_start. RUN -> DRAIN at the edge that issues read address IMG_W*IMG_H-1. DRAIN -> DONE at the edge where the eof pixel transfers. DONE -> IDLE unconditionally after 1 cycle. o_done = (state == DONE). i_start is ignored outside IDLE.
- Read issue rule: in RUN, o_mem_rden = 1 iff (occ + inflight - pop) < 2.
  - occ: skid-buffer entries, 0..2.
  - inflight: read issued last cycle.
  - pop: o_wren & i_ready this cycle.
  - The address increments on each issued read.
- Read data captured into the skid buffer at the edge following its arrival cycle. Sidebands are computed from the issued address and travel with the data.
- Buffer never overflows; capacity 2 covers the 1-cycle RAM latency with zero bubbles.
- Output: o_data/o_wren/o_sof/o_eol/o_eof = buffer head (registered).
  - Once o_wren is high, it and all qualifiers stay stable until transfer.
  - With i_ready held high, the frame streams as IMG_W*IMG_H consecutive o_wren cycles.
- Latency: i_start sampled at edge E0. Read addr 0 is driven in cycle E0-E1. o_wren is first high in the cycle after edge E2.
- Simultaneous push and pop: allowed; occ unchanged.
- i_ready low: reads throttle per the issue rule. No data is lost or duplicated.
- Counters: x wraps IMG_W-1 -> 0 with y+1. No wrap past the last address.

Decomposition:
- pixel_stream_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - DATA_W default
  - pixel beat struct {data, sof, eol, eof}
- One sub-module: pixel_skid_fifo. A 2-entry FIFO of pixel beats with push/pop/occ, registered head output.
- FSM, address/x/y counters and issue logic live in the top module.

Test Plan:
- IMG_W=4, IMG_H=2, RAM[i]=i+16, i_ready=1, pulse i_start -> o_wren high 8 consecutive cycles starting the cycle after the 2nd edge past start. o_data 16..23. o_sof on 16; o_eol on 19 and 23; o_eof on 23. o_done one cycle after the 23 transfer.
- Same frame, i_ready toggled 1,0,0,1,0,1... -> identical sequence 16..23, no gaps/duplicates. While o_wren & !i_ready, o_data stable. occ never exceeds 2.
- i_ready=0 from start -> exactly 2 reads then o_mem_rden stays 0. o_wren high with o_data=16 held. Releasing i_ready streams the remainder.
- i_start pulsed again mid-frame -> ignored, frame completes normally with a single o_done. Back-to-back i_start in the DONE cycle is ignored; i_start in the following IDLE cycle starts a new frame at addr 0.
- i_rst asserted after 3 transfers -> next cycle o_wren=0, o_busy=0, no o_done. A new i_start restarts at addr 0 with o_sof on 16.
- IMG_W=1, IMG_H=1 -> single beat with o_sof, o_eol, o_eof all high, then o_done.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared types for the raster pixel streamer and its skid FIFO.
package pixel_stream_pkg;
    localparam int PIX_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;
endpackage

// File: rtl/pixel_frame_streamer_if.sv
// pixel_frame_streamer_if: pixel stream with ready/valid handshake and frame/line markers.
interface pixel_frame_streamer_if #(parameter int DATA_W = pixel_stream_pkg::PIX_W) ();
    logic [DATA_W-1:0] o_data;
    logic              o_wren;
    logic              i_ready;
    logic              o_sof;
    logic              o_eol;
    logic              o_eof;
    modport master (output o_data, o_wren, o_sof, o_eol, o_eof, input i_ready);
    modport slave (input o_data, o_wren, o_sof, o_eol, o_eof, output i_ready);
endinterface

// File: rtl/pixel_skid_fifo.sv
// pixel_skid_fifo: 2-entry FIFO of pixel beats with a registered head.
module pixel_skid_fifo
    import pixel_stream_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       push,
    input  logic       pop,
    input  beat_t      din,
    output beat_t      head,
    output logic       valid,
    output logic [1:0] occ
);
    beat_t tail;
    assign valid = occ != 2'd0;
    // head is cleared when the FIFO drains so markers never linger on an idle bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop) head <= (occ == 2'd2) ? tail : (push ? din : '0);
            else if (push && occ == 2'd0) head <= din;
            if (push && (occ == 2'd2 || (occ == 2'd1 && !pop))) tail <= din;
        end
    end
endmodule

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: raster-scan reader of a frame RAM feeding a ready/valid pixel stream.
module pixel_frame_streamer
    import pixel_stream_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_rden,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic [DATA_W-1:0]     i_mem_data,
    pixel_frame_streamer_if.master px
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          inflight, pend_sof, pend_eol, pend_eof;
    logic          wren, pop;
    logic [1:0]    occ;
    beat_t         beat_in, head;

    assign pop        = wren & px.i_ready;
    // occupancy after this edge must leave room for the read about to be issued
    assign o_mem_rden = (state == RUN) && (({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
    assign o_busy     = (state == RUN) || (state == DRAIN);
    assign o_done     = state == DONE;
    assign beat_in    = '{data: PIX_W'(i_mem_data), sof: pend_sof, eol: pend_eol, eof: pend_eof};
    assign px.o_data  = DATA_W'(head.data);
    assign px.o_wren  = wren;
    assign px.o_sof   = head.sof;
    assign px.o_eol   = head.eol;
    assign px.o_eof   = head.eof;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_mem_addr <= '0;
            x          <= '0;
            y          <= '0;
            inflight   <= 1'b0;
            pend_sof   <= 1'b0;
            pend_eol   <= 1'b0;
            pend_eof   <= 1'b0;
        end else begin
            inflight <= o_mem_rden;
            if (o_mem_rden) begin
                pend_sof <= (x == '0) && (y == '0);
                pend_eol <= x == X_LAST;
                pend_eof <= (x == X_LAST) && (y == Y_LAST);
                if (o_mem_addr != LAST) begin
                    o_mem_addr <= o_mem_addr + ADDR_W'(1);
                    x          <= (x == X_LAST) ? '0 : x + XW'(1);
                    y          <= (x == X_LAST) ? y + YW'(1) : y;
                end
            end
            case (state)
                IDLE: if (i_start) begin
                    state      <= RUN;
                    o_mem_addr <= '0;
                    x          <= '0;
                    y          <= '0;
                end
                RUN:     if (o_mem_rden && o_mem_addr == LAST) state <= DRAIN;
                DRAIN:   if (pop && head.eof) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pixel_skid_fifo u_fifo (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .push (inflight),
        .pop  (pop),
        .din  (beat_in),
        .head (head),
        .valid(wren),
        .occ  (occ)
    );
endmodule
